// File: rtl/cmd_pkg.sv
// Shared definitions for the copter-side command responder: opcodes,
// default response bytes, frame timeout default and the FSM state type.
package cmd_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] ACK_DEF  = 8'hA5;
  localparam logic [7:0] NACK_DEF = 8'hEE;

  localparam int FRAME_TMO_DEF = 1_000_000;

  typedef enum logic [2:0] {
    RX0,
    RX1,
    RX2,
    DISPATCH,
    WAIT_BATT,
    WAIT_CAL,
    SEND,
    WAIT_SENT
  } cmd_state_e;

endpackage

// File: rtl/cmd_frame_rx.sv
// Assembles opcode/data-high/data-low bytes into one frame and discards a
// partial frame after FRAME_TMO idle cycles. frm_rdy is combinational so the
// responder can enter DISPATCH on the edge that samples the third byte.
module cmd_frame_rx
  import cmd_pkg::*;
#(
  parameter int FRAME_TMO = FRAME_TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_byte,
  input  logic        busy,
  output logic        frm_rdy,
  output logic [7:0]  opcode,
  output logic [15:0] data
);

  localparam int TMO_W = $clog2(FRAME_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};

  cmd_state_e       state_r, state_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic [7:0]       opcode_r, data_hi_r;
  logic             accept_s, tmo_s, frm_rdy_s;

  assign accept_s = rx_rdy & ~busy;
  assign tmo_s    = (tmo_cnt_r == TMO_LAST);

  // Byte-position sequencing; an accepted byte wins over timeout expiry.
  always_comb begin
    state_s   = state_r;
    frm_rdy_s = 1'b0;
    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
    case (state_r)
      RX0: begin
        tmo_cnt_s = TMO_ZERO;
        if (accept_s) state_s = RX1;
        else          state_s = RX0;
      end
      RX1: begin
        if (accept_s) begin
          state_s   = RX2;
          tmo_cnt_s = TMO_ZERO;
        end else if (tmo_s) begin
          state_s   = RX0;
          tmo_cnt_s = TMO_ZERO;
        end else begin
          state_s = RX1;
        end
      end
      RX2: begin
        if (accept_s) begin
          state_s   = RX0;
          frm_rdy_s = 1'b1;
          tmo_cnt_s = TMO_ZERO;
        end else if (tmo_s) begin
          state_s   = RX0;
          tmo_cnt_s = TMO_ZERO;
        end else begin
          state_s = RX2;
        end
      end
      default: begin
        state_s   = RX0;
        tmo_cnt_s = TMO_ZERO;
      end
    endcase
  end

  // State, timeout counter and captured header bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RX0;
      tmo_cnt_r <= TMO_ZERO;
      opcode_r  <= 8'h00;
      data_hi_r <= 8'h00;
    end else begin
      state_r   <= state_s;
      tmo_cnt_r <= tmo_cnt_s;
      if (state_r == RX0 && accept_s) opcode_r  <= rx_byte;
      if (state_r == RX1 && accept_s) data_hi_r <= rx_byte;
    end
  end

  assign frm_rdy = frm_rdy_s;
  assign opcode  = opcode_r;
  assign data    = {data_hi_r, rx_byte};

endmodule

// File: rtl/cmd_responder.sv
// Executes received command frames and returns one response byte per frame.
// Optional link-loss watchdog enabled by defining CMD_WDOG_EN.
module cmd_responder
  import cmd_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE  = ACK_DEF,
  parameter logic [7:0] NACK_BYTE = NACK_DEF,
  parameter int         FRAME_TMO = FRAME_TMO_DEF
`ifdef CMD_WDOG_EN
  , parameter int       WDOG_CYCLES = 50_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_rdy,
  input  logic [7:0]         rx_byte,
  output logic [7:0]         resp,
  output logic               send_resp,
  input  logic               resp_sent,
  output logic               strt_cnv,
  input  logic               cnv_cmplt,
  input  logic [11:0]        batt,
  output logic               strt_cal,
  input  logic               cal_done,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               motors_off,
  output logic               wdog_trip
);

  cmd_state_e         state_r, state_s;
  logic               frm_rdy_s;
  logic [7:0]         frm_opcode_s, opcode_r, opcode_s;
  logic [15:0]        frm_data_s, data_r, data_s;
  logic [7:0]         resp_r, resp_s;
  logic               send_resp_r, send_resp_s;
  logic               strt_cnv_r, strt_cnv_s, strt_cal_r, strt_cal_s;
  logic signed [15:0] d_ptch_r, d_ptch_s, d_roll_r, d_roll_s, d_yaw_r, d_yaw_s;
  logic [8:0]         thrst_r, thrst_s;
  logic               motors_off_r, motors_off_s;
  logic               wdog_trip_r, wdog_trip_s;
  logic               batt_unused_s;

`ifdef CMD_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_ZERO = {WDOG_W{1'b0}};
  logic [WDOG_W-1:0] wdog_cnt_r, wdog_cnt_s;
`endif

  // Only the upper 8 battery bits are reported back over the link.
  assign batt_unused_s = ^batt[3:0];

  cmd_frame_rx #(
    .FRAME_TMO (FRAME_TMO)
  ) u_frame_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_rdy  (rx_rdy),
    .rx_byte (rx_byte),
    .busy    (state_r != RX0),
    .frm_rdy (frm_rdy_s),
    .opcode  (frm_opcode_s),
    .data    (frm_data_s)
  );

  // Next-state and next-register values for the command execution FSM.
  always_comb begin
    state_s      = state_r;
    opcode_s     = opcode_r;
    data_s       = data_r;
    resp_s       = resp_r;
    send_resp_s  = 1'b0;
    strt_cnv_s   = 1'b0;
    strt_cal_s   = 1'b0;
    d_ptch_s     = d_ptch_r;
    d_roll_s     = d_roll_r;
    d_yaw_s      = d_yaw_r;
    thrst_s      = thrst_r;
    motors_off_s = motors_off_r;
    wdog_trip_s  = 1'b0;
`ifdef CMD_WDOG_EN
    wdog_cnt_s   = wdog_cnt_r;
`endif
    case (state_r)
      RX0: begin
        if (frm_rdy_s) begin
          state_s  = DISPATCH;
          opcode_s = frm_opcode_s;
          data_s   = frm_data_s;
        end else begin
          state_s = RX0;
        end
      end
      DISPATCH: begin
        // Immediate-response opcodes skip SEND so send_resp lands with the write.
        state_s     = WAIT_SENT;
        send_resp_s = 1'b1;
        resp_s      = ACK_BYTE;
        case (opcode_r)
          REQ_BATT: begin
            state_s     = WAIT_BATT;
            send_resp_s = 1'b0;
            resp_s      = resp_r;
            strt_cnv_s  = 1'b1;
          end
          SET_PTCH:  d_ptch_s = data_r;
          SET_ROLL:  d_roll_s = data_r;
          SET_YAW:   d_yaw_s  = data_r;
          SET_THRST: begin
            thrst_s      = data_r[8:0];
            motors_off_s = 1'b0;
          end
          CALIBRATE: begin
            state_s      = WAIT_CAL;
            send_resp_s  = 1'b0;
            resp_s       = resp_r;
            strt_cal_s   = 1'b1;
            motors_off_s = 1'b1;
          end
          EMER_LAND: begin
            d_ptch_s = 16'sh0000;
            d_roll_s = 16'sh0000;
            d_yaw_s  = 16'sh0000;
            thrst_s  = 9'h000;
          end
          MTRS_OFF:  motors_off_s = 1'b1;
          default:   resp_s = NACK_BYTE;
        endcase
      end
      WAIT_BATT: begin
        if (cnv_cmplt) begin
          resp_s  = batt[11:4];
          state_s = SEND;
        end else begin
          state_s = WAIT_BATT;
        end
      end
      WAIT_CAL: begin
        if (cal_done) begin
          resp_s  = ACK_BYTE;
          state_s = SEND;
        end else begin
          state_s = WAIT_CAL;
        end
      end
      SEND: begin
        send_resp_s = 1'b1;
        state_s     = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (resp_sent) state_s = RX0;
        else           state_s = WAIT_SENT;
      end
      default: state_s = RX0;
    endcase
`ifdef CMD_WDOG_EN
    // Trip only while idle or assembling; otherwise hold at the last count.
    if (state_r == DISPATCH) begin
      wdog_cnt_s = WDOG_ZERO;
    end else if (wdog_cnt_r == WDOG_LAST) begin
      if (state_r == RX0) begin
        wdog_trip_s = 1'b1;
        wdog_cnt_s  = WDOG_ZERO;
        d_ptch_s    = 16'sh0000;
        d_roll_s    = 16'sh0000;
        d_yaw_s     = 16'sh0000;
        thrst_s     = 9'h000;
      end else begin
        wdog_cnt_s = wdog_cnt_r;
      end
    end else begin
      wdog_cnt_s = wdog_cnt_r + WDOG_W'(1);
    end
`endif
  end

  // Register bank for FSM state, captured frame and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RX0;
      opcode_r     <= 8'h00;
      data_r       <= 16'h0000;
      resp_r       <= 8'h00;
      send_resp_r  <= 1'b0;
      strt_cnv_r   <= 1'b0;
      strt_cal_r   <= 1'b0;
      d_ptch_r     <= 16'sh0000;
      d_roll_r     <= 16'sh0000;
      d_yaw_r      <= 16'sh0000;
      thrst_r      <= 9'h000;
      motors_off_r <= 1'b1;
      wdog_trip_r  <= 1'b0;
`ifdef CMD_WDOG_EN
      wdog_cnt_r   <= WDOG_ZERO;
`endif
    end else begin
      state_r      <= state_s;
      opcode_r     <= opcode_s;
      data_r       <= data_s;
      resp_r       <= resp_s;
      send_resp_r  <= send_resp_s;
      strt_cnv_r   <= strt_cnv_s;
      strt_cal_r   <= strt_cal_s;
      d_ptch_r     <= d_ptch_s;
      d_roll_r     <= d_roll_s;
      d_yaw_r      <= d_yaw_s;
      thrst_r      <= thrst_s;
      motors_off_r <= motors_off_s;
      wdog_trip_r  <= wdog_trip_s;
`ifdef CMD_WDOG_EN
      wdog_cnt_r   <= wdog_cnt_s;
`endif
    end
  end

  assign resp       = resp_r;
  assign send_resp  = send_resp_r;
  assign strt_cnv   = strt_cnv_r;
  assign strt_cal   = strt_cal_r;
  assign d_ptch     = d_ptch_r;
  assign d_roll     = d_roll_r;
  assign d_yaw      = d_yaw_r;
  assign thrst      = thrst_r;
  assign motors_off = motors_off_r;
  assign wdog_trip  = wdog_trip_r;

endmodule

// File: tb/tb_cmd_responder.sv
// Scoreboard bench for cmd_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every send_resp pulse.
module tb_cmd_responder;

  localparam int TMO  = 64;
  localparam int WDOG = 1000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        rx_rdy = 1'b0, resp_sent = 1'b0, cnv_cmplt = 1'b0, cal_done = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [11:0] batt = 12'h000;
  logic [7:0]  resp;
  logic        send_resp, strt_cnv, strt_cal, motors_off, wdog_trip;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;

  typedef struct { logic [7:0] resp; int at; } exp_t;
  exp_t exp_q[$];

  int         n_cmp = 0, n_bad = 0, cyc = 0;
  bit         tx_busy = 1'b0;
  logic [7:0] tx_held;

  cmd_responder #(
    .FRAME_TMO (TMO)
`ifdef CMD_WDOG_EN
    , .WDOG_CYCLES (WDOG)
`endif
  ) dut (
    .clk (clk), .rst (rst), .rx_rdy (rx_rdy), .rx_byte (rx_byte),
    .resp (resp), .send_resp (send_resp), .resp_sent (resp_sent),
    .strt_cnv (strt_cnv), .cnv_cmplt (cnv_cmplt), .batt (batt),
    .strt_cal (strt_cal), .cal_done (cal_done),
    .d_ptch (d_ptch), .d_roll (d_roll), .d_yaw (d_yaw), .thrst (thrst),
    .motors_off (motors_off), .wdog_trip (wdog_trip)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && send_resp) begin
      if (exp_q.size() == 0) begin
        chk("unexpected send_resp", 32'(send_resp), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp", 32'(resp), 32'(e.resp));
        if (e.at >= 0) chk("send_resp cycle", cyc, e.at);
      end
    end
  end

  // Transmitter model: acknowledges each request a few cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && send_resp) begin
        tx_held = resp;
        tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 resp_sent = 1'b1;
        @(negedge clk);
        chk("resp held", 32'(resp), 32'(tx_held));
        @(posedge clk);
        #1 resp_sent = 1'b0;
        tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int t);
    @(posedge clk); #1;
    rx_rdy = 1'b1; rx_byte = b; t = cyc;
    @(posedge clk); #1;
    rx_rdy = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] hi,
                            input logic [7:0] lo, input int gap, output int t);
    int d;
    send_byte(op, d);
    repeat (gap) @(posedge clk);
    send_byte(hi, d);
    @(posedge clk);
    send_byte(lo, t);
  endtask

  task automatic expect_resp(input logic [7:0] r, input int at);
    exp_q.push_back('{resp: r, at: at});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("response drained", exp_q.size(), 0);
  endtask

  task automatic cmd(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                     input logic [7:0] r, output int t);
    send_frame(op, hi, lo, 1, t);
    expect_resp(r, t + 2);
    wait_idle();
  endtask

  task automatic wait_pulse(input int sel, input int tmax, output int at);
    at = -1;
    for (int i = 0; i < tmax; i++) begin
      @(negedge clk);
      if ((sel == 0 && strt_cnv) || (sel == 1 && strt_cal) || (sel == 2 && wdog_trip)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_in(input int sel, output int c);
    @(posedge clk); #1;
    if (sel == 0) cnv_cmplt = 1'b1;
    else          cal_done  = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    cnv_cmplt = 1'b0;
    cal_done  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, at, c, d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst d_ptch", 32'(d_ptch), 32'h0);
    chk("rst d_roll", 32'(d_roll), 32'h0);
    chk("rst d_yaw", 32'(d_yaw), 32'h0);
    chk("rst thrst", 32'(thrst), 32'h0);
    chk("rst motors_off", 32'(motors_off), 32'h1);
    chk("rst resp", 32'(resp), 32'h0);
    chk("rst strobes", 32'({send_resp, strt_cnv, strt_cal, wdog_trip}), 32'h0);

    // Pitch write with exact output timing
    send_frame(8'h02, 8'h00, 8'h2A, 1, t);
    expect_resp(8'hA5, t + 2);
    @(negedge clk);
    chk("d_ptch at T+1", 32'(d_ptch), 32'h0);
    @(negedge clk);
    chk("d_ptch at T+2", 32'(d_ptch), 32'h002A);
    wait_idle();

    cmd(8'h04, 8'hFF, 8'h1F, 8'hA5, t);
    chk("d_yaw negative", 32'(d_yaw), 32'hFF1F);
    cmd(8'h05, 8'h01, 8'h20, 8'hA5, t);
    chk("thrst", 32'(thrst), 32'h120);
    chk("motors_off cleared", 32'(motors_off), 32'h0);
    cmd(8'h07, 8'h00, 8'h00, 8'hA5, t);
    chk("emer d_ptch", 32'(d_ptch), 32'h0);
    chk("emer d_yaw", 32'(d_yaw), 32'h0);
    chk("emer thrst", 32'(thrst), 32'h0);

    // Battery request
    batt = 12'hC84;
    send_frame(8'h01, 8'h00, 8'h00, 1, t);
    wait_pulse(0, 10, at);
    chk("strt_cnv cycle", at, t + 2);
    repeat (19) @(posedge clk);
    pulse_in(0, c);
    expect_resp(8'hC8, c + 2);
    wait_idle();

    // Calibration; a frame sent while waiting must be dropped
    send_frame(8'h06, 8'h00, 8'h00, 1, t);
    wait_pulse(1, 10, at);
    chk("strt_cal cycle", at, t + 2);
    chk("cal motors_off", 32'(motors_off), 32'h1);
    send_frame(8'h02, 8'h00, 8'h55, 1, d);
    repeat (5) @(posedge clk);
    pulse_in(1, c);
    expect_resp(8'hA5, c + 2);
    wait_idle();
    chk("dropped frame d_ptch", 32'(d_ptch), 32'h0);
    chk("cal motors_off kept", 32'(motors_off), 32'h1);

    // Byte arriving exactly in the timeout expiry cycle is still accepted
    cmd(8'h02, 8'h12, 8'h34, 8'hA5, t);
    send_frame(8'h03, 8'h00, 8'h77, TMO - 2, t);
    expect_resp(8'hA5, t + 2);
    wait_idle();
    chk("boundary d_roll", 32'(d_roll), 32'h0077);

    // Fragment discarded after timeout
    send_byte(8'h02, d);
    @(posedge clk);
    send_byte(8'h00, d);
    repeat (TMO + 5) @(posedge clk);
    cmd(8'h03, 8'h00, 8'h3A, 8'hA5, t);
    chk("after tmo d_roll", 32'(d_roll), 32'h003A);
    chk("after tmo d_ptch", 32'(d_ptch), 32'h1234);

    // Reset mid-frame and mid-wait
    send_byte(8'h02, d);
    send_byte(8'hAB, d);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    cmd(8'h03, 8'h00, 8'h44, 8'hA5, t);
    chk("post-reset d_ptch", 32'(d_ptch), 32'h0);
    chk("post-reset d_roll", 32'(d_roll), 32'h0044);
    send_frame(8'h01, 8'h00, 8'h00, 1, t);
    wait_pulse(0, 10, at);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    pulse_in(0, c);
    repeat (10) @(negedge clk);
    chk("reset wait d_roll", 32'(d_roll), 32'h0);
    chk("reset wait motors_off", 32'(motors_off), 32'h1);

    cmd(8'h03, 8'h00, 8'h44, 8'hA5, t);
    cmd(8'h09, 8'h12, 8'h34, 8'hEE, t);
    chk("nack d_roll kept", 32'(d_roll), 32'h0044);
    chk("nack d_ptch kept", 32'(d_ptch), 32'h0);
    cmd(8'h05, 8'h00, 8'h10, 8'hA5, t);
    cmd(8'h08, 8'h00, 8'h00, 8'hA5, t);
    chk("mtrs_off", 32'(motors_off), 32'h1);
    chk("mtrs_off thrst kept", 32'(thrst), 32'h010);

    // Completion strobes outside their wait states are ignored
    pulse_in(0, c);
    pulse_in(1, c);
    repeat (10) @(negedge clk);

`ifdef CMD_WDOG_EN
    cmd(8'h05, 8'h01, 8'h20, 8'hA5, t);
    chk("wdog pre thrst", 32'(thrst), 32'h120);
    wait_pulse(2, WDOG + 50, at);
    chk("wdog_trip delay", at - t, WDOG + 2);
    chk("wdog thrst", 32'(thrst), 32'h0);
    chk("wdog d_roll", 32'(d_roll), 32'h0);
    chk("wdog motors_off kept", 32'(motors_off), 32'h0);
    @(negedge clk);
    chk("wdog_trip one cycle", 32'(wdog_trip), 32'h0);
`else
    wait_pulse(2, WDOG + 100, at);
    chk("wdog_trip stays 0", at, -1);
`endif
    repeat (20) @(negedge clk);
    chk("leftover expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_responder.md
# cmd_responder

Copter-side end of the wireless command link. Assembles 3-byte command frames (opcode, data high byte, data low byte) arriving from the UART receiver and executes them. It updates the flight setpoint registers, starts battery conversions or calibration, and returns exactly one response byte per frame through the UART transmitter handshake. It sits between the UART wrapper and the flight controller, battery A2D interface and inertial calibration logic inside the QuadCopter top level.

## Interface
- ACK_BYTE, 8'hA5, response byte for every accepted non-battery command
- NACK_BYTE, 8'hEE, response byte for an unknown opcode
- FRAME_TMO, 1_000_000, idle cycles after which a partial frame is discarded
- WDOG_CYCLES, 50_000_000, link-loss watchdog period in cycles (used only with CMD_WDOG_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_rdy  in  1  one-cycle pulse; rx_byte valid
- rx_byte  in  8  received byte
- resp  out  8  response byte; held stable from send_resp until resp_sent
- send_resp  out  1  one-cycle pulse requesting transmission of resp
- resp_sent  in  1  one-cycle pulse; transmitter finished
- strt_cnv  out  1  one-cycle pulse; start battery A2D conversion
- cnv_cmplt  in  1  one-cycle pulse; batt valid
- batt  in  12  battery A2D result
- strt_cal  out  1  one-cycle pulse; start inertial calibration
- cal_done  in  1  one-cycle pulse; calibration finished
- d_ptch, d_roll, d_yaw  out  16  signed desired pitch, roll and yaw
- thrst  out  9  desired thrust (data[8:0])
- motors_off  out  1  motors disabled
- wdog_trip  out  1  one-cycle pulse; watchdog forced a landing

## Operation
- States: RX0, RX1, RX2, DISPATCH, WAIT_BATT, WAIT_CAL, SEND, WAIT_SENT.
- RX0→RX1→RX2 advance on rx_rdy, capturing opcode, data[15:8] and data[7:0]. The third byte moves the FSM to DISPATCH.
- DISPATCH actions by opcode:
  - 01 REQ_BATT: pulse strt_cnv, go to WAIT_BATT. On cnv_cmplt, resp=batt[11:4], go to SEND.
  - 02/03/04: write d_ptch, d_roll or d_yaw from data; resp=ACK_BYTE.
  - 05: write thrst=data[8:0], clear motors_off; resp=ACK_BYTE.
  - 06 CALIBRATE: pulse strt_cal, set motors_off, go to WAIT_CAL. On cal_done, resp=ACK_BYTE, go to SEND. motors_off stays set.
  - 07 EMER_LAND: zero d_ptch, d_roll, d_yaw and thrst; resp=ACK_BYTE.
  - 08 MTRS_OFF: set motors_off; resp=ACK_BYTE.
  - Any other opcode: no register change; resp=NACK_BYTE.
- SEND: pulse send_resp, go to WAIT_SENT. On resp_sent, go to RX0.
- rx_rdy pulses in DISPATCH through WAIT_SENT are dropped. No queueing.
- Frame timeout: in RX1 or RX2, a counter counts cycles without rx_rdy. At FRAME_TMO the FSM returns to RX0, the partial frame is discarded and no response is sent. If rx_rdy arrives in the expiry cycle, the byte is accepted and the counter restarts.

## Timing
- Third byte rx_rdy at cycle T: DISPATCH at T+1. Setpoint outputs change at T+2 and send_resp is high at T+2.
- strt_cnv/strt_cal are high at T+2. send_resp pulses 2 cycles after cnv_cmplt or cal_done.
- Reset values: d_ptch=d_roll=d_yaw=0, thrst=0, motors_off=1, resp=0, send_resp=0, strt_cnv=0, strt_cal=0, wdog_trip=0, state RX0, all counters 0.
- Reset asserted mid-frame or mid-wait abandons the operation. No response is issued after release.
- cnv_cmplt, cal_done and resp_sent are ignored outside their wait states.

## Configuration
- CMD_WDOG_EN defined: a counter clears on every frame reaching DISPATCH and otherwise increments. At WDOG_CYCLES, if the FSM is in RX0, RX1 or RX2:
  - pulse wdog_trip;
  - perform EMER_LAND register effects;
  - reset the counter.
  - No response is sent and the FSM state is unchanged.
- CMD_WDOG_EN undefined: no counter is built, wdog_trip is tied 0 and WDOG_CYCLES is unused.

## Structure
- cmd_pkg: opcode localparams (REQ_BATT..MTRS_OFF), default ACK/NACK values, and the state enum typedef.
- Sub-module cmd_frame_rx holds the RX0–RX2 byte assembly and frame timeout. It outputs frm_rdy (pulse), opcode and data[15:0], and takes a busy input that drops bytes while the responder is busy.

## Test plan
- Reset → motors_off=1, all setpoints 0. Frame 02 00 2A → d_ptch=16'h002A at T+2, send_resp once, resp=8'hA5.
- Frame 04 FF 1F → d_yaw=16'hFF1F (negative). Then 05 01 20 → thrst=9'h120, motors_off=0. Then 07 00 00 → all setpoints 0, ACK.
- Frame 01 00 00 with batt=12'hC84 and cnv_cmplt 20 cycles after strt_cnv → resp=8'hC8. send_resp fires exactly 2 cycles after cnv_cmplt.
- Frame 06 00 00 → strt_cal pulse, motors_off=1, no send_resp until cal_done. Response is ACK. Bytes sent during WAIT_CAL are dropped.
- Send 02 00, idle FRAME_TMO cycles, then 03 00 3A → no response to the fragment, d_roll=16'h003A, d_ptch unchanged. Opcode 0x09 → resp=8'hEE.
- With CMD_WDOG_EN and WDOG_CYCLES=1000: set thrst, send nothing for 1000 cycles → wdog_trip pulse, setpoints zero. Without the macro, wdog_trip stays 0.
